// File: rtl/muldiv_alu.sv
// muldiv_alu -- iterative RV32M multiply/divide unit for the execute stage.
//
// Runs MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. The datapath is
// radix-2 and takes one step per cycle: shift-add for multiply and restoring
// division for divide. Both work on operand magnitudes. The result is negated
// at the end when the operand signs call for it.
//
// Handshake: a request transfers on a rising edge where in_valid and in_ready
// are both high. A result transfers on an edge where out_valid and out_ready
// are both high. The requester holds op/src1/src2 stable until in_ready.
//
// Optional build macro: MULDIV_EARLY_EXIT_EN. When it is defined, three cases
// skip CALC and go straight to DONE: divide-by-zero, signed overflow, and a
// multiply with a zero operand. When it is not defined, every operation takes
// XLEN CALC cycles, and the divide-by-zero quotient is forced at the end.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   unit can accept a request (IDLE only)
//   op         funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   src1       operand 1 (multiplicand / dividend)
//   src2       operand 2 (multiplier / divisor)
//   flush      synchronous kill of any in-flight or pending result
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts the result
//   out        registered result
//   zero_flag  1 when out == 0, registered with out
module muldiv_alu #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out,
   output logic            zero_flag
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(XLEN);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [2:0]         op_q;
   logic [2*XLEN-1:0]  acc_q;    // mul: {partial product, multiplier}; div: {remainder, quotient}
   logic [XLEN-1:0]    opnd_q;   // mul: multiplicand magnitude; div: divisor magnitude
   logic               neg_q;    // product / quotient sign
   logic               rneg_q;   // remainder sign (dividend sign)
   logic               dz_q;     // divide by zero seen at accept

   // ---------------- request decode ----------------
   logic               is_div_in, sgn1_in, sgn2_in, s1_in, s2_in;
   logic [XLEN-1:0]    mag1_in, mag2_in;
   logic               dz_in, ovf_in, accept;
   logic               early_hit;
   logic [XLEN-1:0]    early_res;

   always_comb begin
      is_div_in = op[2];
      sgn1_in   = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
      sgn2_in   = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
      s1_in     = sgn1_in && src1[XLEN-1];
      s2_in     = sgn2_in && src2[XLEN-1];
      mag1_in   = s1_in ? (~src1 + 1'b1) : src1;
      mag2_in   = s2_in ? (~src2 + 1'b1) : src2;
      dz_in     = is_div_in && (src2 == '0);
      // Only the signed divide ops (DIV, REM) can overflow.
      ovf_in    = is_div_in && !op[0] && (src1 == MIN_NEG) && (src2 == '1);
      accept    = (state == IDLE) && in_valid && !flush;
   end

`ifdef MULDIV_EARLY_EXIT_EN
   always_comb begin
      early_hit = dz_in || ovf_in || (!is_div_in && ((src1 == '0) || (src2 == '0)));
      early_res = '0;
      if (dz_in)
         early_res = op[1] ? src1 : '1;          // REM/REMU -> dividend, DIV/DIVU -> all ones
      else if (ovf_in)
         early_res = op[1] ? '0 : src1;          // REM -> 0, DIV -> most negative value
   end
`else
   always_comb begin
      early_hit = 1'b0;
      early_res = '0;
   end
`endif

   // ---------------- one iteration step ----------------
   logic [XLEN-1:0]    hi, lo;
   logic [XLEN:0]      mul_sum, cand, diff;
   logic               ge;
   logic [2*XLEN-1:0]  mul_nxt, div_nxt, acc_nxt, prod_fix;
   logic [XLEN-1:0]    q_res, r_res, mul_res, div_res, calc_res;

   always_comb begin
      hi      = acc_q[2*XLEN-1:XLEN];
      lo      = acc_q[XLEN-1:0];
      // Multiply: add the multiplicand when the multiplier LSB is set, then shift right.
      mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
      mul_nxt = {mul_sum, lo[XLEN-1:1]};
      // Restoring divide: shift the next dividend bit in and subtract when it fits.
      cand    = {hi, lo[XLEN-1]};
      ge      = (cand >= {1'b0, opnd_q});
      diff    = cand - {1'b0, opnd_q};
      div_nxt = {(ge ? diff[XLEN-1:0] : cand[XLEN-1:0]), lo[XLEN-2:0], ge};
      acc_nxt = op_q[2] ? div_nxt : mul_nxt;

      // Sign fix-up on the value the final step produces.
      prod_fix = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
      mul_res  = (op_q == 3'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      q_res    = neg_q  ? (~acc_nxt[XLEN-1:0] + 1'b1)         : acc_nxt[XLEN-1:0];
      r_res    = rneg_q ? (~acc_nxt[2*XLEN-1:XLEN] + 1'b1)    : acc_nxt[2*XLEN-1:XLEN];
      // Divide-by-zero remainder comes out as the dividend naturally; the
      // quotient has to be forced to all ones.
      div_res  = op_q[1] ? r_res : (dz_q ? '1 : q_res);
      calc_res = op_q[2] ? div_res : mul_res;
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (in_valid) state_nxt = early_hit ? DONE : CALC;
            CALC: if (cnt == CNT_ONE) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE) && rst_n;
   assign out_valid = (state == DONE);

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         op_q      <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         neg_q     <= 1'b0;
         rneg_q    <= 1'b0;
         dz_q      <= 1'b0;
         out       <= '0;
         zero_flag <= 1'b1;
      end else if (accept) begin
         op_q   <= op;
         neg_q  <= s1_in ^ s2_in;
         rneg_q <= s1_in;
         dz_q   <= dz_in;
         cnt    <= CNT_MAX;
         if (is_div_in) begin
            opnd_q <= mag2_in;
            acc_q  <= {{XLEN{1'b0}}, mag1_in};
         end else begin
            opnd_q <= mag1_in;
            acc_q  <= {{XLEN{1'b0}}, mag2_in};
         end
         if (early_hit) begin
            out       <= early_res;
            zero_flag <= (early_res == '0);
         end
      end else if ((state == CALC) && !flush) begin
         acc_q <= acc_nxt;
         cnt   <= cnt - CNT_ONE;
         if (cnt == CNT_ONE) begin
            out       <= calc_res;
            zero_flag <= (calc_res == '0);
         end
      end
   end

endmodule

// File: doc/muldiv_alu.md
Name: muldiv_alu

Overview:
- Parametrised multi-cycle arithmetic unit for the RV32M extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the single-cycle integer ALU in the execute stage. The core stalls on the valid/ready handshake while an operation is in flight.
- Uses an iterative radix-2 datapath: shift-add for multiply, restoring division for divide. Each operation takes one step per cycle.
- Produces a registered result and a zero flag, with the same meaning as the integer ALU's zero flag.

Parameters:
- XLEN, 32, operand and result width in bits (8..64, even). Sets the iteration count.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request (IDLE only).
- op  input  3  operation, funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- src1  input  XLEN  operand 1 (multiplicand / dividend).
- src2  input  XLEN  operand 2 (multiplier / divisor).
- flush  input  1  synchronous kill of any in-flight or pending result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out  output  XLEN  result, registered.
- zero_flag  output  1  1 when out == 0, registered with out.

Behaviour:
- Reset (async on rst_n low):
  - State goes to IDLE; counter = 0.
  - out_valid = 0, out = 0, zero_flag = 1, in_ready = 0 while rst_n is low.
  - Asserting reset mid-operation discards the operation with no output.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready = 1. When in_valid is high (and flush is low), latch op and operand magnitudes plus sign bits, load counter = XLEN, go to CALC.
  - CALC: one step per cycle; counter decrements each cycle. When counter == 1, the final step and sign fix-up complete and the state goes to DONE.
  - DONE: out_valid = 1. out and zero_flag are held stable until out_ready is high, then the state goes to IDLE. A new request is not accepted in the same cycle as the result handshake.
- Latency: the accept edge is cycle 0. CALC occupies cycles 1..XLEN. out_valid is first high in cycle XLEN+1 (33 for XLEN=32). Throughput is one operation per XLEN+2 cycles minimum.
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: src1 signed, src2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - MUL: sign-agnostic; returns the low XLEN bits.
- Method: operate on magnitudes and negate the result at the end.
  - Product sign = s1 ^ s2.
  - Quotient sign = s1 ^ s2.
  - Remainder sign = s1 (the dividend's sign).
- Product register is 2*XLEN bits. MUL returns [XLEN-1:0]; MULH/MULHSU/MULHU return [2*XLEN-1:XLEN].
- Special cases (results are RISC-V defined; no exceptions raised):
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give src1.
  - Signed overflow (DIV, src1 = most negative value, src2 = -1): quotient = src1, remainder = 0.
- flush:
  - High in any state: go to IDLE next cycle and clear out_valid.
  - flush has priority over in_valid (no accept) and over out_ready.
  - out and zero_flag keep their last values.
- in_valid while in CALC or DONE is ignored; the requester must hold its request until in_ready.
- op values are all defined, so there is no default path.

Optional Feature:
- Macro: MULDIV_EARLY_EXIT_EN.
- Defined:
  - Divide-by-zero and signed-overflow cases are detected at accept and skip CALC. IDLE goes directly to DONE, so out_valid is high in cycle 1.
  - A multiply with src1 == 0 or src2 == 0 also exits early with result 0.
- Undefined: every operation takes the full XLEN+1 cycle latency. Special-case results are still identical, forced at the end of CALC.

Test Plan:
- MUL src1=7, src2=0xFFFFFFFD (XLEN=32) -> out=0xFFFFFFEB, zero_flag=0, out_valid first high exactly 33 cycles after accept; in_ready low throughout.
- Upper-half multiplies:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- Divides:
  - DIV -7/2 -> 0xFFFFFFFD.
  - REM -7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
  - REM 6/3 -> 0 with zero_flag=1.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
  - Latency is 1 cycle with MULDIV_EARLY_EXIT_EN defined, 33 without.
- Backpressure: hold out_ready low 5 cycles in DONE -> out, zero_flag and out_valid stable, in_ready=0; out_ready high -> IDLE next cycle, in_ready=1.
- flush pulse in CALC cycle 10 -> out_valid never rises, in_ready=1 next cycle; a following DIVU 9/3 -> 3 correct. A separate run asserts rst_n low mid-CALC -> out=0, zero_flag=1, out_valid=0 immediately.
